// File: rtl/arp_cam_if.sv
// Bundle of the command, CAM write, CAM lookup and completion signals of the ARP CAM controller.
// The master side issues commands and models the CAM. The slave side is the controller.
interface arp_cam_if #(
  parameter int K = 32,
  parameter int V = 48,
  parameter int A = 3,
  parameter int D = 84
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [K-1:0] cmd_key;
  logic [V-1:0] cmd_value;

  logic         ram_req;
  logic         ram_op;
  logic [A-1:0] ram_addr;
  logic [D-1:0] ram_data;

  logic         lookup_req_valid;
  logic [K-1:0] lookup_req_key;
  logic         lookup_resp_valid;
  logic         lookup_resp_hit;
  logic [A-1:0] lookup_resp_addr;

  logic         done_valid;
  logic [1:0]   done_status;
  logic [A-1:0] done_addr;
  logic [A:0]   occupancy;
  logic         evict;

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_value,
    output lookup_resp_valid, lookup_resp_hit, lookup_resp_addr,
    input  cmd_ready, ram_req, ram_op, ram_addr, ram_data,
    input  lookup_req_valid, lookup_req_key,
    input  done_valid, done_status, done_addr, occupancy, evict
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_value,
    input  lookup_resp_valid, lookup_resp_hit, lookup_resp_addr,
    output cmd_ready, ram_req, ram_op, ram_addr, ram_data,
    output lookup_req_valid, lookup_req_key,
    output done_valid, done_status, done_addr, occupancy, evict
  );
endinterface

// File: rtl/arp_cam_ctrl.sv
// ARP CAM controller: runs each insert/delete command through lookup, write and completion phases.
// It tracks the live-entry bitmap, the occupancy and a round-robin victim pointer used when the table is full.
module arp_cam_ctrl #(
  parameter int K     = 32,
  parameter int V     = 48,
  parameter int N     = 8,
  parameter int A     = 3,
  parameter int D     = 84,
  parameter int VALID = 82
) (
  input  logic     clk_i,
  input  logic     rst_i,
  arp_cam_if.slave bus_io
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_WAIT, S_WRITE, S_DONE
  } state_e;

  state_e       state_q,  state_d;
  logic [A-1:0] idx_q,    idx_d;
  logic         op_q,     op_d;
  logic [K-1:0] key_q,    key_d;
  logic [V-1:0] val_q,    val_d;
  logic [A-1:0] addr_q,   addr_d;
  logic [1:0]   status_q, status_d;
  logic         evict_q,  evict_d;
  logic [N-1:0] bitmap_q, bitmap_d;
  logic [A-1:0] victim_q, victim_d;

  logic [A-1:0] free_idx;
  logic [A:0]   occ;
  logic [D-1:0] entry;
  logic         full;

  // Lowest-index free slot: scanning downwards lets the smallest index win.
  always_comb begin
    free_idx = '0;
    occ      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!bitmap_q[i]) free_idx = A'(i);
      occ = occ + (A+1)'(bitmap_q[i]);
    end
  end

  assign full = &bitmap_q;

  always_comb begin
    entry              = '0;
    entry[K-1:0]       = key_q;
    entry[K+V-1:K]     = val_q;
    entry[VALID]       = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    key_d    = key_q;
    val_d    = val_q;
    addr_d   = addr_q;
    status_d = status_q;
    evict_d  = evict_q;
    bitmap_d = bitmap_q;
    victim_d = victim_q;

    bus_io.cmd_ready        = 1'b0;
    bus_io.ram_req          = 1'b0;
    bus_io.ram_op           = 1'b0;
    bus_io.ram_addr         = '0;
    bus_io.ram_data         = '0;
    bus_io.lookup_req_valid = 1'b0;
    bus_io.lookup_req_key   = '0;
    bus_io.done_valid       = 1'b0;
    bus_io.done_status      = '0;
    bus_io.done_addr        = '0;
    bus_io.evict            = 1'b0;
    bus_io.occupancy        = occ;

    unique case (state_q)
      S_INIT: begin
        // Hold the sweep off while reset is asserted so it starts cleanly on release.
        bus_io.ram_req  = !rst_i;
        bus_io.ram_op   = !rst_i;
        bus_io.ram_addr = idx_q;
        idx_d           = idx_q + A'(1);
        if (idx_q == A'(N - 1)) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        bus_io.cmd_ready = 1'b1;
        if (bus_io.cmd_valid) begin
          op_d    = bus_io.cmd_op;
          key_d   = bus_io.cmd_key;
          val_d   = bus_io.cmd_value;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        bus_io.lookup_req_valid = 1'b1;
        bus_io.lookup_req_key   = key_q;
        state_d                 = S_WAIT;
      end
      S_WAIT: begin
        if (bus_io.lookup_resp_valid) begin
          evict_d = 1'b0;
          state_d = S_WRITE;
          if (op_q) begin
            if (bus_io.lookup_resp_hit) begin
              addr_d   = bus_io.lookup_resp_addr;
              status_d = 2'd2;
            end else begin
              addr_d   = '0;
              status_d = 2'd3;
              state_d  = S_DONE;
            end
          end else if (bus_io.lookup_resp_hit) begin
            addr_d   = bus_io.lookup_resp_addr;
            status_d = 2'd1;
          end else if (full) begin
            addr_d   = victim_q;
            status_d = 2'd0;
            evict_d  = 1'b1;
            victim_d = (victim_q == A'(N - 1)) ? '0 : victim_q + A'(1);
          end else begin
            addr_d   = free_idx;
            status_d = 2'd0;
          end
        end
      end
      S_WRITE: begin
        bus_io.ram_req   = 1'b1;
        bus_io.ram_op    = 1'b1;
        bus_io.ram_addr  = addr_q;
        bus_io.ram_data  = op_q ? '0 : entry;
        bitmap_d[addr_q] = !op_q;
        state_d          = S_DONE;
      end
      S_DONE: begin
        bus_io.done_valid  = 1'b1;
        bus_io.done_status = status_q;
        bus_io.done_addr   = addr_q;
        bus_io.evict       = evict_q;
        state_d            = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_INIT;
      idx_q    <= '0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      status_q <= '0;
      evict_q  <= 1'b0;
      bitmap_q <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      status_q <= status_d;
      evict_q  <= evict_d;
      bitmap_q <= bitmap_d;
      victim_q <= victim_d;
    end
  end

  always_ff @(posedge clk_i) begin
    key_q <= key_d;
    val_q <= val_d;
  end

endmodule

// File: tb/tb_arp_cam_ctrl.sv
// Bench for arp_cam_ctrl: a behavioural CAM with 2-cycle lookup latency, directed and random commands.
// Expected results come from a key/slot table model.
module tb_arp_cam_ctrl;
  localparam int K = 32, V = 48, N = 8, A = 3, D = 84, VALID = 82;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arp_cam_if #(.K(K), .V(V), .A(A), .D(D)) bus ();

  arp_cam_ctrl #(.K(K), .V(V), .N(N), .A(A), .D(D), .VALID(VALID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  // Behavioural CAM: stores written entries, answers a lookup two cycles later.
  logic [D-1:0] cam_mem [N];
  logic         s1_vld  = 1'b0;
  logic [K-1:0] s1_key  = '0;
  logic         cam_vld = 1'b0;
  logic         cam_hit = 1'b0;
  logic [A-1:0] cam_addr = '0;
  logic         inj = 1'b0;

  always @(posedge clk) begin
    if (bus.ram_req) cam_mem[bus.ram_addr] <= bus.ram_data;
    s1_vld   <= bus.lookup_req_valid;
    s1_key   <= bus.lookup_req_key;
    cam_vld  <= s1_vld;
    cam_hit  <= 1'b0;
    cam_addr <= '0;
    if (s1_vld) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cam_mem[i][VALID] && cam_mem[i][K-1:0] == s1_key) begin
          cam_hit  <= 1'b1;
          cam_addr <= A'(i);
        end
      end
    end
  end

  assign bus.lookup_resp_valid = cam_vld | inj;
  assign bus.lookup_resp_hit   = cam_hit;
  assign bus.lookup_resp_addr  = cam_addr;

  // Reference table model
  bit           m_live [N];
  logic [K-1:0] m_key  [N];
  int           m_victim;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_live[i] = 1'b0;
      m_key[i]  = '0;
    end
    m_victim = 0;
  endfunction

  function automatic int m_find(input logic [K-1:0] key);
    for (int i = 0; i < N; i++) if (m_live[i] && m_key[i] == key) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_live[i]);
    return c;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < N; i++) if (!m_live[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic sweep_check();
    for (int i = 0; i < N; i++) begin
      check("sweep_req", bus.ram_req, 1);
      check("sweep_op", bus.ram_op, 1);
      check("sweep_addr", bus.ram_addr, i);
      check("sweep_data", bus.ram_data, 0);
      check("sweep_ready", bus.cmd_ready, 0);
      nclk();
    end
    check("post_sweep_ready", bus.cmd_ready, 1);
    check("post_sweep_req", bus.ram_req, 0);
    check("post_sweep_occ", bus.occupancy, 0);
  endtask

  task automatic do_cmd(input bit op, input logic [K-1:0] key, input logic [V-1:0] val);
    int f, exp_addr, exp_status, waited;
    bit exp_evict, writes;
    logic [D-1:0] exp_data;
    f = m_find(key);
    exp_evict = 1'b0;
    exp_data  = '0;
    writes    = 1'b1;
    if (!op) begin
      exp_data = (D'(1) << VALID) | (D'(val) << K) | D'(key);
      if (f >= 0) begin
        exp_addr = f; exp_status = 1;
      end else if (m_count() < N) begin
        exp_addr = m_free(); exp_status = 0;
      end else begin
        exp_addr = m_victim; exp_status = 0; exp_evict = 1'b1;
        m_victim = (m_victim + 1) % N;
      end
      m_live[exp_addr] = 1'b1;
      m_key[exp_addr]  = key;
    end else if (f >= 0) begin
      exp_addr = f; exp_status = 2;
      m_live[f] = 1'b0;
    end else begin
      exp_addr = 0; exp_status = 3; writes = 1'b0;
    end

    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 32) begin
      nclk();
      waited++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_key   = key;
    bus.cmd_value = val;
    nclk();
    bus.cmd_valid = 1'b0;
    bus.cmd_key   = ~key;
    bus.cmd_value = ~val;
    check("lookup_vld", bus.lookup_req_valid, 1);
    check("lookup_key", bus.lookup_req_key, key);
    check("ready_busy", bus.cmd_ready, 0);
    check("no_ram_t1", bus.ram_req, 0);
    nclk();
    check("lookup_once", bus.lookup_req_valid, 0);
    check("lookup_key_idle", bus.lookup_req_key, 0);
    check("no_ram_t2", bus.ram_req, 0);
    nclk();
    check("no_ram_t3", bus.ram_req, 0);
    check("no_done_t3", bus.done_valid, 0);
    nclk();
    if (writes) begin
      check("ram_req", bus.ram_req, 1);
      check("ram_op", bus.ram_op, 1);
      check("ram_addr", bus.ram_addr, exp_addr);
      check("ram_data", bus.ram_data, exp_data);
      check("no_done_write", bus.done_valid, 0);
      nclk();
    end
    check("no_ram_done", bus.ram_req, 0);
    check("done_valid", bus.done_valid, 1);
    check("done_status", bus.done_status, exp_status);
    check("done_addr", bus.done_addr, exp_addr);
    check("evict", bus.evict, exp_evict);
    check("occupancy", bus.occupancy, m_count());
    nclk();
    check("done_single", bus.done_valid, 0);
    check("done_status_idle", bus.done_status, 0);
    check("ready_after_done", bus.cmd_ready, 1);
  endtask

  initial begin
    logic [K-1:0] rk;
    logic [V-1:0] rv;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_key   = '0;
    bus.cmd_value = '0;
    m_reset();

    repeat (3) nclk();
    check("rst_ready", bus.cmd_ready, 0);
    check("rst_done", bus.done_valid, 0);
    check("rst_occ", bus.occupancy, 0);
    check("rst_lookup", bus.lookup_req_valid, 0);
    check("rst_ram_req", bus.ram_req, 0);
    check("rst_evict", bus.evict, 0);
    check("rst_done_addr", bus.done_addr, 0);
    rst = 1'b0;
    #1;
    sweep_check();

    // Stray lookup response while idle must be ignored
    inj = 1'b1;
    nclk();
    inj = 1'b0;
    check("stray_ready", bus.cmd_ready, 1);
    check("stray_ram", bus.ram_req, 0);
    check("stray_done", bus.done_valid, 0);

    do_cmd(1'b0, 32'h0A000001, 48'h112233445566);
    do_cmd(1'b0, 32'h0A000001, 48'hAABBCCDDEEFF);
    for (int i = 2; i <= 8; i++) do_cmd(1'b0, 32'h0A000000 + K'(i), 48'h000100000000 * V'(i));
    do_cmd(1'b0, 32'h0A000009, 48'h090909090909);
    do_cmd(1'b0, 32'h0A00000A, 48'h0A0A0A0A0A0A);
    do_cmd(1'b1, 32'h0B000000, 48'h0);
    do_cmd(1'b1, 32'h0A000004, 48'h0);
    do_cmd(1'b0, 32'h0A00000B, 48'h0B0B0B0B0B0B);

    for (int n = 0; n < 60; n++) begin
      rk = 32'hC0A80000 | K'($urandom_range(0, 11));
      rv = {16'($urandom), 32'($urandom)};
      do_cmd($urandom_range(0, 9) < 3, rk, rv);
    end

    // Reset while waiting for the lookup response
    check("pre_abort_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_key   = 32'h0A0000FF;
    bus.cmd_value = 48'hFFEEDDCCBBAA;
    nclk();
    bus.cmd_valid = 1'b0;
    nclk();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nclk();
      check("abort_no_done", bus.done_valid, 0);
      check("abort_no_ram", bus.ram_req, 0);
      check("abort_ready", bus.cmd_ready, 0);
      check("abort_occ", bus.occupancy, 0);
    end
    rst = 1'b0;
    #1;
    m_reset();
    sweep_check();

    for (int n = 0; n < 12; n++) begin
      rk = 32'hC0A80000 | K'($urandom_range(0, 9));
      rv = {16'($urandom), 32'($urandom)};
      do_cmd($urandom_range(0, 9) < 2, rk, rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
